// File: rtl/regfile_sequencer.sv
// Purpose: command-driven master that sequences save/load ports of a 6-entry register file.
// Latency: accept edge to rsp_valid is LOADI 2, MOVE 3, SWAP 5, READ 2, illegal selector 1.
// Backpressure: one command in flight; cmd_ready only in IDLE; response held until rsp_ready.
module regfile_sequencer #(
    parameter int WIDTH    = 8,
    parameter int SELW     = 3,
    parameter int REGCOUNT = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SELW-1:0]  cmd_src,
    input  logic [SELW-1:0]  cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             save,
    output logic [SELW-1:0]  saveselector,
    output logic [WIDTH-1:0] savebus,
    output logic [SELW-1:0]  loadselector,
    input  logic [WIDTH-1:0] loadbus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR_B,
        S_WR_A,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [SELW:0] REG_LIMIT = (SELW+1)'(REGCOUNT);

    state_t           state;
    logic [1:0]       op_q;
    logic [SELW-1:0]  src_q;
    logic [SELW-1:0]  dst_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] tmp_a;
    logic [WIDTH-1:0] tmp_b;

    logic src_ok;
    logic dst_ok;
    logic cmd_legal;

    assign src_ok    = ({1'b0, cmd_src} < REG_LIMIT);
    assign dst_ok    = ({1'b0, cmd_dst} < REG_LIMIT);
    assign cmd_ready = (state == S_IDLE);

    // Only the selectors the opcode actually uses take part in the legality check.
    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_op)
            OP_LOADI: cmd_legal = dst_ok;
            OP_READ:  cmd_legal = src_ok;
            default:  cmd_legal = src_ok && dst_ok;
        endcase
    end

    // Sequencer FSM; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            op_q         <= OP_LOADI;
            src_q        <= '0;
            dst_q        <= '0;
            imm_q        <= '0;
            tmp_a        <= '0;
            tmp_b        <= '0;
            save         <= 1'b0;
            saveselector <= '0;
            savebus      <= '0;
            loadselector <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        src_q <= cmd_src;
                        dst_q <= cmd_dst;
                        imm_q <= cmd_imm;
                        if (!cmd_legal) begin
                            // Rejected commands go straight to the response, no register access.
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (cmd_op == OP_LOADI) begin
                            state        <= S_WR_A;
                            save         <= 1'b1;
                            saveselector <= cmd_dst;
                            savebus      <= cmd_imm;
                        end else begin
                            state        <= S_RD_A;
                            loadselector <= cmd_src;
                        end
                    end
                end
                S_RD_A: begin
                    tmp_a <= loadbus;
                    if (op_q == OP_MOVE) begin
                        state        <= S_WR_A;
                        loadselector <= '0;
                        save         <= 1'b1;
                        saveselector <= dst_q;
                        savebus      <= loadbus;
                    end else if (op_q == OP_SWAP) begin
                        state        <= S_RD_B;
                        loadselector <= dst_q;
                    end else begin
                        state        <= S_RESP;
                        loadselector <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b0;
                        rsp_data     <= loadbus;
                    end
                end
                S_RD_B: begin
                    // Both reads are complete before the first write, so no forwarding is needed.
                    tmp_b        <= loadbus;
                    loadselector <= '0;
                    state        <= S_WR_B;
                    save         <= 1'b1;
                    saveselector <= dst_q;
                    savebus      <= tmp_a;
                end
                S_WR_B: begin
                    state        <= S_WR_A;
                    save         <= 1'b1;
                    saveselector <= src_q;
                    savebus      <= tmp_b;
                end
                S_WR_A: begin
                    state     <= S_RESP;
                    save      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= (op_q == OP_LOADI) ? imm_q : tmp_a;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Purpose: self-checking bench for regfile_sequencer with an attached register file.
// Latency: measures accept-to-response cycles against the per-opcode figures.
// Backpressure: exercises held rsp_ready, ignored commands while busy and back-to-back traffic.
module tb_regfile_sequencer;

    logic       clock;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src;
    logic [2:0] cmd_dst;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       save;
    logic [2:0] saveselector;
    logic [7:0] savebus;
    logic [2:0] loadselector;
    logic [7:0] loadbus;

    int checks   = 0;
    int failures = 0;

    regfile_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_src      (cmd_src),
        .cmd_dst      (cmd_dst),
        .cmd_imm      (cmd_imm),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .save         (save),
        .saveselector (saveselector),
        .savebus      (savebus),
        .loadselector (loadselector),
        .loadbus      (loadbus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file attached to the sequencer: combinational read, write on the clock edge.
    logic [7:0] rf [0:7];
    assign loadbus = (loadselector < 3'd6) ? rf[loadselector] : 8'h00;
    always @(posedge clock) begin
        if (save && saveselector < 3'd6) rf[saveselector] <= savebus;
    end

    // Every write strobe seen on a clock edge, as {selector, data}.
    logic [10:0] wr_q [$];
    always @(posedge clock) begin
        if (save) wr_q.push_back({saveselector, savebus});
    end

    // Reference register contents, updated from the command semantics only.
    logic [7:0] mdl [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [7:0] imm, input int hold);
        logic        legal;
        logic [7:0]  exp_data;
        int          exp_lat;
        logic [10:0] exp_wr [$];
        int          base;
        int          lat;
        int          guard;
        logic [7:0]  a;
        logic [7:0]  b;

        case (op)
            2'b00:   legal = (dst < 3'd6);
            2'b11:   legal = (src < 3'd6);
            default: legal = (src < 3'd6) && (dst < 3'd6);
        endcase
        a = mdl[src];
        b = mdl[dst];
        exp_wr.delete();
        if (!legal) begin
            exp_data = 8'h00; exp_lat = 1;
        end else if (op == 2'b00) begin
            exp_data = imm; exp_lat = 2;
            exp_wr.push_back({dst, imm});
        end else if (op == 2'b01) begin
            exp_data = a; exp_lat = 3;
            exp_wr.push_back({dst, a});
        end else if (op == 2'b10) begin
            exp_data = a; exp_lat = 5;
            exp_wr.push_back({dst, a});
            exp_wr.push_back({src, b});
        end else begin
            exp_data = a; exp_lat = 2;
        end

        @(negedge clock);
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        base      = wr_q.size();
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", {31'd0, cmd_ready}, 32'd0);

        lat = 1;
        while (!rsp_valid && lat < 20) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_src   = 3'($urandom_range(0, 7));
            cmd_dst   = 3'($urandom_range(0, 7));
            cmd_imm   = 8'($urandom_range(0, 255));
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            lat++;
        end
        cmd_valid = 1'b0;
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("latency", lat, exp_lat);
        check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, !legal});

        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_dst   = 3'd0;
            cmd_imm   = 8'($urandom_range(0, 255));
            @(posedge clock);
            #1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);

        check("write_count", wr_q.size() - base, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && base + i < wr_q.size(); i++) begin
            check("write_sel_data", {21'd0, wr_q[base+i]}, {21'd0, exp_wr[i]});
        end

        if (legal) begin
            if (op == 2'b00) mdl[dst] = imm;
            else if (op == 2'b01) mdl[dst] = a;
            else if (op == 2'b10) begin
                mdl[dst] = a;
                mdl[src] = b;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [2:0] s;
        logic [2:0] d;

        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_src   = 3'd0;
        cmd_dst   = 3'd0;
        cmd_imm   = 8'h00;
        rsp_ready = 1'b0;
        #1;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_save", {31'd0, save}, 32'd0);
        check("reset_saveselector", {29'd0, saveselector}, 32'd0);
        check("reset_savebus", {24'd0, savebus}, 32'd0);
        check("reset_loadselector", {29'd0, loadselector}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Give every register a known value.
        for (int i = 0; i < 6; i++) run_cmd(2'b00, 3'd0, 3'(i), 8'($urandom_range(0, 255)), 0);

        // Directed scenarios.
        run_cmd(2'b00, 3'd0, 3'd4, 8'hA5, 0);
        run_cmd(2'b00, 3'd0, 3'd1, 8'h11, 0);
        run_cmd(2'b00, 3'd0, 3'd2, 8'h22, 0);
        run_cmd(2'b10, 3'd1, 3'd2, 8'h00, 0);
        run_cmd(2'b11, 3'd1, 3'd0, 8'h00, 0);
        run_cmd(2'b01, 3'd7, 3'd3, 8'h00, 0);
        run_cmd(2'b00, 3'd0, 3'd6, 8'h5A, 0);
        run_cmd(2'b11, 3'd3, 3'd0, 8'h00, 5);
        run_cmd(2'b10, 3'd3, 3'd3, 8'h00, 0);
        run_cmd(2'b11, 3'd3, 3'd0, 8'h00, 0);

        // Reset while the SWAP is in its first write cycle.
        @(negedge clock);
        base      = wr_q.size();
        cmd_op    = 2'b10;
        cmd_src   = 3'd1;
        cmd_dst   = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("swap_wrb_save", {31'd0, save}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_save", {31'd0, save}, 32'd0);
        check("midreset_saveselector", {29'd0, saveselector}, 32'd0);
        check("midreset_savebus", {24'd0, savebus}, 32'd0);
        check("midreset_loadselector", {29'd0, loadselector}, 32'd0);
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("midreset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("midreset_no_write", wr_q.size() - base, 32'd0);
        run_cmd(2'b11, 3'd1, 3'd0, 8'h00, 0);
        run_cmd(2'b11, 3'd2, 3'd0, 8'h00, 0);

        // Back-to-back MOVE traffic.
        for (int i = 0; i < 8; i++) begin
            s = 3'($urandom_range(0, 5));
            d = 3'($urandom_range(0, 5));
            run_cmd(2'b01, s, d, 8'h00, 0);
        end

        // Random mix, including illegal selectors and response backpressure.
        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            d = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            run_cmd(2'($urandom_range(0, 3)), s, d, 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)));
        end

        // Final sweep: every register matches the reference.
        for (int i = 0; i < 6; i++) run_cmd(2'b11, 3'(i), 3'd0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
